// File: rtl/sd_spi_cmd.sv
`default_nettype none
// ============================================================================
// Module      : sd_spi_cmd
// Description : SPI-mode SD card command engine. Sends one 48-bit command,
//               polls for R1, optionally collects up to four response bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_spi_cmd #(
    parameter int CLK_DIV_SLOW = 250,
    parameter int CLK_DIV_FAST = 2,
    parameter int NCR_MAX      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        fast,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [6:0]  cmd_crc,
    input  logic [2:0]  extra_bytes,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  r1,
    output logic [31:0] resp_data,
    output logic        sd_cclk,
    output logic        sd_cmd,
    input  logic        sd_data0,
    output logic        sd_cs
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_CMD   = 3'd2,
        S_POLL  = 3'd3,
        S_EXTRA = 3'd4,
        S_TRAIL = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [15:0] c_div_slow_last = 16'(CLK_DIV_SLOW - 1);
    localparam logic [15:0] c_div_fast_last = 16'(CLK_DIV_FAST - 1);
    localparam logic [7:0]  c_ncr_last      = 8'(NCR_MAX - 1);

    state_t      state_q,    state_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        timeout_q,  timeout_d;
    logic [7:0]  r1_q,       r1_d;
    logic [31:0] resp_q,     resp_d;
    logic        sclk_q,     sclk_d;
    logic        mosi_q,     mosi_d;
    logic        cs_q,       cs_d;
    logic [15:0] div_cnt_q,  div_cnt_d;
    logic [2:0]  bit_cnt_q,  bit_cnt_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  tx_q,       tx_d;
    logic [7:0]  rx_q,       rx_d;
    logic        fast_q,     fast_d;
    logic [5:0]  idx_q,      idx_d;
    logic [31:0] arg_q,      arg_d;
    logic [6:0]  crc_q,      crc_d;
    logic [2:0]  extra_q,    extra_d;

    logic [15:0] w_div_last;
    logic        w_shifting;
    logic        w_byte_done;
    logic [2:0]  w_extra_eff;
    logic [7:0]  w_load;
    logic        w_load_en;

    function automatic logic [7:0] cmd_byte(
        input logic [2:0]  n,
        input logic [5:0]  idx,
        input logic [31:0] arg,
        input logic [6:0]  crc
    );
        case (n)
            3'd0:    cmd_byte = {2'b01, idx};
            3'd1:    cmd_byte = arg[31:24];
            3'd2:    cmd_byte = arg[23:16];
            3'd3:    cmd_byte = arg[15:8];
            3'd4:    cmd_byte = arg[7:0];
            default: cmd_byte = {crc, 1'b1};
        endcase
    endfunction

    assign w_div_last  = fast_q ? c_div_fast_last : c_div_slow_last;
    assign w_shifting  = (state_q != S_IDLE) && (state_q != S_DONE);
    assign w_extra_eff = (extra_q > 3'd4) ? 3'd4 : extra_q;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        timeout_d  = timeout_q;
        r1_d       = r1_q;
        resp_d     = resp_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_d       = cs_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        fast_d     = fast_q;
        idx_d      = idx_q;
        arg_d      = arg_q;
        crc_d      = crc_q;
        extra_d    = extra_q;
        w_byte_done = 1'b0;
        w_load      = 8'hFF;
        w_load_en   = 1'b0;

        // Bit engine: sample on the rising toggle, shift on the falling one.
        // The 8th falling edge closes the byte; the next byte's MSB goes out
        // on that same edge so there is no gap between bytes.
        if (w_shifting) begin
            if (div_cnt_q == w_div_last) begin
                div_cnt_d = '0;
                sclk_d    = ~sclk_q;
                if (!sclk_q) begin
                    rx_d = {rx_q[6:0], sd_data0};
                end else if (bit_cnt_q == 3'd7) begin
                    bit_cnt_d   = '0;
                    w_byte_done = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    tx_d      = {tx_q[6:0], 1'b1};
                    mosi_d    = tx_q[6];
                end
            end else begin
                div_cnt_d = div_cnt_q + 16'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    fast_d     = fast;
                    idx_d      = cmd_index;
                    arg_d      = cmd_arg;
                    crc_d      = cmd_crc;
                    extra_d    = extra_bytes;
                    busy_d     = 1'b1;
                    cs_d       = 1'b0;
                    timeout_d  = 1'b0;
                    r1_d       = 8'h00;
                    resp_d     = 32'h0;
                    sclk_d     = 1'b0;
                    div_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    w_load_en  = 1'b1;
                    state_d    = S_PRE;
                end
            end
            S_PRE: begin
                if (w_byte_done) begin
                    byte_cnt_d = '0;
                    w_load     = cmd_byte(3'd0, idx_q, arg_q, crc_q);
                    w_load_en  = 1'b1;
                    state_d    = S_CMD;
                end
            end
            S_CMD: begin
                if (w_byte_done) begin
                    w_load_en = 1'b1;
                    if (byte_cnt_q == 8'd5) begin
                        byte_cnt_d = '0;
                        state_d    = S_POLL;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        w_load     = cmd_byte(byte_cnt_q[2:0] + 3'd1, idx_q, arg_q, crc_q);
                    end
                end
            end
            S_POLL: begin
                if (w_byte_done) begin
                    w_load_en = 1'b1;
                    if (!rx_q[7]) begin
                        r1_d       = rx_q;
                        byte_cnt_d = '0;
                        state_d    = (w_extra_eff == 3'd0) ? S_TRAIL : S_EXTRA;
                    end else if (byte_cnt_q == c_ncr_last) begin
                        r1_d      = 8'hFF;
                        timeout_d = 1'b1;
                        state_d   = S_TRAIL;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
            S_EXTRA: begin
                if (w_byte_done) begin
                    w_load_en = 1'b1;
                    resp_d    = {resp_q[23:0], rx_q};
                    if (byte_cnt_q == {5'd0, w_extra_eff - 3'd1}) begin
                        state_d = S_TRAIL;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
            S_TRAIL: begin
                if (w_byte_done) begin
                    cs_d      = 1'b1;
                    mosi_d    = 1'b1;
                    div_cnt_d = '0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_load_en) begin
            tx_d   = w_load;
            mosi_d = w_load[7];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            r1_q       <= 8'h00;
            resp_q     <= 32'h0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b1;
            cs_q       <= 1'b1;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            tx_q       <= 8'hFF;
            rx_q       <= 8'h00;
            fast_q     <= 1'b0;
            idx_q      <= '0;
            arg_q      <= '0;
            crc_q      <= '0;
            extra_q    <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            r1_q       <= r1_d;
            resp_q     <= resp_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_q       <= cs_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            fast_q     <= fast_d;
            idx_q      <= idx_d;
            arg_q      <= arg_d;
            crc_q      <= crc_d;
            extra_q    <= extra_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign r1        = r1_q;
    assign resp_data = resp_q;
    assign sd_cclk   = sclk_q;
    assign sd_cmd    = mosi_q;
    assign sd_cs     = cs_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_cmd.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_spi_cmd
// Description : Scoreboard bench for sd_spi_cmd with an SD card MISO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_spi_cmd;

    localparam int NCR = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        fast;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [6:0]  cmd_crc;
    logic [2:0]  extra_bytes;
    logic        sd_data0 = 1'b1;
    wire         busy, done, timeout, sd_cclk, sd_cmd, sd_cs;
    wire  [7:0]  r1;
    wire  [31:0] resp_data;

    sd_spi_cmd #(
        .CLK_DIV_SLOW(250),
        .CLK_DIV_FAST(2),
        .NCR_MAX     (NCR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .fast       (fast),
        .cmd_index  (cmd_index),
        .cmd_arg    (cmd_arg),
        .cmd_crc    (cmd_crc),
        .extra_bytes(extra_bytes),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .r1         (r1),
        .resp_data  (resp_data),
        .sd_cclk    (sd_cclk),
        .sd_cmd     (sd_cmd),
        .sd_data0   (sd_data0),
        .sd_cs      (sd_cs)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_seen = 0;

    // Card model state: bytes the card answers after the 7 command-phase bytes
    logic [7:0]  miso_q[$];
    logic [7:0]  cap_q[$];
    logic [7:0]  mosi_sr = 8'h00;
    int          nbits = 0;
    int          rise_cnt = 0;
    int          last_rise = 0;
    int          prev_rise = 0;

    // Scoreboard queues
    logic [7:0]  exp_r1_q[$];
    logic [31:0] exp_resp_q[$];
    logic        exp_to_q[$];
    int          exp_len_q[$];
    logic [7:0]  exp_frame_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rsp(input int k);
        if (k < miso_q.size()) return miso_q[k];
        return 8'hFF;
    endfunction

    function automatic logic miso_bit(input int n);
        logic [7:0] b;
        if (n / 8 < 7) return 1'b1;
        b = rsp(n / 8 - 7);
        return b[7 - (n % 8)];
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge sd_cclk) begin
        mosi_sr = {mosi_sr[6:0], sd_cmd};
        nbits++;
        if (nbits % 8 == 0) cap_q.push_back(mosi_sr);
        sd_data0  = miso_bit(nbits);
        prev_rise = last_rise;
        last_rise = cyc;
        rise_cnt++;
    end

    always @(negedge sd_cs) begin
        nbits = 0;
        cap_q.delete();
        sd_data0 = miso_bit(0);
    end

    // Reference model: frame and results derived directly from the protocol
    task automatic expect_txn(input logic [5:0] idx, input logic [31:0] arg,
                              input logic [6:0] crc, input logic [2:0] ext);
        logic [7:0]  fr[$];
        logic [7:0]  b;
        logic [7:0]  e_r1;
        logic [31:0] e_resp;
        logic        e_to;
        int          hit;
        int          n;
        fr.push_back(8'hFF);
        fr.push_back({2'b01, idx});
        fr.push_back(arg[31:24]);
        fr.push_back(arg[23:16]);
        fr.push_back(arg[15:8]);
        fr.push_back(arg[7:0]);
        fr.push_back({crc, 1'b1});
        hit = -1;
        for (int k = 0; k < NCR; k++) begin
            fr.push_back(8'hFF);
            b = rsp(k);
            if (b < 8'h80) begin
                hit = k;
                break;
            end
        end
        e_resp = 32'h0;
        if (hit < 0) begin
            e_r1 = 8'hFF;
            e_to = 1'b1;
        end else begin
            e_r1 = rsp(hit);
            e_to = 1'b0;
            n = (ext > 3'd4) ? 4 : int'(ext);
            for (int j = 1; j <= n; j++) begin
                fr.push_back(8'hFF);
                e_resp = (e_resp << 8) | 32'(rsp(hit + j));
            end
        end
        fr.push_back(8'hFF);
        exp_r1_q.push_back(e_r1);
        exp_resp_q.push_back(e_resp);
        exp_to_q.push_back(e_to);
        exp_len_q.push_back(fr.size());
        foreach (fr[i]) exp_frame_q.push_back(fr[i]);
    endtask

    logic [7:0] mon_b;
    int         mon_n;

    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            done_seen++;
            if (exp_r1_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("r1", 32'(r1), 32'(exp_r1_q.pop_front()));
                check("resp_data", resp_data, exp_resp_q.pop_front());
                check("timeout", 32'(timeout), 32'(exp_to_q.pop_front()));
                check("cs_high_at_done", 32'(sd_cs), 32'd1);
                check("cclk_low_at_done", 32'(sd_cclk), 32'd0);
                check("busy_low_at_done", 32'(busy), 32'd0);
                mon_n = exp_len_q.pop_front();
                check("frame_len", 32'(cap_q.size()), 32'(mon_n));
                for (int i = 0; i < mon_n; i++) begin
                    mon_b = exp_frame_q.pop_front();
                    check($sformatf("frame_byte%0d", i),
                          (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hDEAD, 32'(mon_b));
                end
            end
        end
    end

    task automatic flush_expect();
        exp_r1_q.delete();
        exp_resp_q.delete();
        exp_to_q.delete();
        exp_len_q.delete();
        exp_frame_q.delete();
    endtask

    // Caller sits on a negedge; start is seen by the next rising edge.
    task automatic issue(input logic f, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [6:0] crc, input logic [2:0] ext);
        fast = f; cmd_index = idx; cmd_arg = arg; cmd_crc = crc; extra_bytes = ext;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_seen;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_seen != d0) break;
        end
        if (done_seen == d0) begin
            check("done_within_budget", 32'd0, 32'd1);
            flush_expect();
        end
        @(negedge clk);
    endtask

    task automatic wait_bytes(input int k, input int budget);
        for (int i = 0; i < budget && cap_q.size() < k; i++) @(negedge clk);
        if (cap_q.size() < k) check("bytes_within_budget", 32'(cap_q.size()), 32'(k));
    endtask

    task automatic measure_period(input int want, input int budget);
        int r0;
        r0 = rise_cnt;
        for (int i = 0; i < budget && rise_cnt < r0 + 2; i++) @(negedge clk);
        if (rise_cnt < r0 + 2) check("cclk_edges_within_budget", 32'd0, 32'd1);
        else check("cclk_period", 32'(last_rise - prev_rise), 32'(want));
    endtask

    task automatic idle_quiet(input int n);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sd_cclk !== 1'b0 || sd_cs !== 1'b1 || sd_cmd !== 1'b1) ok = 1'b0;
        end
        check("idle_lines_quiet", 32'(ok), 32'd1);
    endtask

    int         d_before;
    int         lat;
    logic [5:0] r_idx;
    logic [31:0] r_arg;
    logic [6:0] r_crc;
    logic [2:0] r_ext;

    initial begin
        rst = 1'b1; start = 1'b0; fast = 1'b0;
        cmd_index = '0; cmd_arg = '0; cmd_crc = '0; extra_bytes = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_r1", 32'(r1), 32'h00);
        check("rst_resp", resp_data, 32'h0);
        check("rst_lines", {29'd0, sd_cclk, sd_cmd, sd_cs}, 32'b011);

        // CMD0 in slow mode, start on the first cycle after reset release
        rst = 1'b0;
        miso_q = '{8'hFF, 8'h01};
        expect_txn(6'd0, 32'h0, 7'h4A, 3'd0);
        issue(1'b0, 6'd0, 32'h0, 7'h4A, 3'd0);
        check("busy_after_start", 32'(busy), 32'd1);
        measure_period(500, 3000);
        wait_done(50000);
        idle_quiet(20);

        // CMD8 with a 4-byte R7 payload, fast clock
        miso_q = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        expect_txn(6'd8, 32'h0000_01AA, 7'h43, 3'd4);
        issue(1'b1, 6'd8, 32'h0000_01AA, 7'h43, 3'd4);
        measure_period(4, 100);
        wait_done(3000);

        // Card never answers
        miso_q.delete();
        expect_txn(6'd55, 32'h1234_5678, 7'h11, 3'd4);
        issue(1'b1, 6'd55, 32'h1234_5678, 7'h11, 3'd4);
        wait_done(3000);
        idle_quiet(10);

        // Reset during the third command byte
        miso_q = '{8'h01};
        issue(1'b1, 6'd0, 32'h0, 7'h4A, 3'd0);
        wait_bytes(3, 2000);
        repeat (5) @(negedge clk);
        d_before = done_seen;
        rst = 1'b1;
        @(negedge clk);
        check("abort_lines", {28'd0, sd_cs, sd_cclk, sd_cmd, busy}, 32'b1010);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("no_done_after_abort", 32'(done_seen), 32'(d_before));
        miso_q = '{8'hFF, 8'h01};
        expect_txn(6'd0, 32'h0, 7'h4A, 3'd0);
        issue(1'b1, 6'd0, 32'h0, 7'h4A, 3'd0);
        wait_done(3000);

        // Start pulsed while polling must be ignored
        miso_q = '{8'hFF, 8'hFF, 8'hFF, 8'h05};
        d_before = done_seen;
        expect_txn(6'd2, 32'hCAFE_0042, 7'h3C, 3'd0);
        issue(1'b1, 6'd2, 32'hCAFE_0042, 7'h3C, 3'd0);
        wait_bytes(8, 2000);
        issue(1'b1, 6'd17, 32'hFFFF_0000, 7'h7F, 3'd3);
        wait_done(3000);
        repeat (300) @(negedge clk);
        check("single_done_on_busy_start", 32'(done_seen), 32'(d_before + 1));

        // Randomised commands, response latency and payload length
        for (int t = 0; t < 24; t++) begin
            lat = $urandom_range(0, 9);
            miso_q.delete();
            for (int j = 0; j < lat; j++) miso_q.push_back(8'h80 | 8'($urandom_range(0, 127)));
            miso_q.push_back(8'($urandom_range(0, 127)));
            for (int j = 0; j < 4; j++) miso_q.push_back(8'($urandom_range(0, 255)));
            r_idx = 6'($urandom);
            r_arg = $urandom;
            r_crc = 7'($urandom);
            r_ext = 3'($urandom);
            expect_txn(r_idx, r_arg, r_crc, r_ext);
            issue(1'b1, r_idx, r_arg, r_crc, r_ext);
            wait_done(3000);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        repeat (20) @(negedge clk);
        check("scoreboard_empty", 32'(exp_len_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
